// File: rtl/reg_bank_wb.sv
// reg_bank_wb: 32 x 32-bit register bank. It has one write port fed by the
// write-back selector, two registered read ports (rs/rt) feeding the A/B
// operand latches, and a combinational debug read port.
// Entry 0 always reads as zero. Entry SP_INDEX resets to SP_RESET.
module reg_bank_wb #(
  parameter int          SP_INDEX = 29,
  parameter logic [31:0] SP_RESET = 32'd227,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_reg_1,
  input  logic [4:0]  read_reg_2,
  output logic [31:0] read_data_1,
  output logic [31:0] read_data_2,
  input  logic [4:0]  dbg_reg,
  output logic [31:0] dbg_data
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] read_data_1_q, read_data_1_d;
  logic [31:0] read_data_2_q, read_data_2_d;
  logic        wr_en;

  // Writes to index 0 are dropped, so entry 0 stays at its reset value of zero.
  assign wr_en = reg_write && (write_reg != 5'd0);

  // Read-port resolution: r0 reads zero, then the in-flight write, then stored data.
  function automatic logic [31:0] resolve_read(input logic [4:0] idx);
    logic [31:0] val;
    val = regs_q[idx];
    if (idx == 5'd0) begin
      val = 32'd0;
    end else if (BYPASS && reg_write && (write_reg == idx)) begin
      val = write_data;
    end
    return val;
  endfunction

  // Next-state for the storage and the read latches. Reset overrides any write.
  always_comb begin
    regs_d        = regs_q;
    read_data_1_d = resolve_read(read_reg_1);
    read_data_2_d = resolve_read(read_reg_2);
    if (wr_en) begin
      regs_d[write_reg] = write_data;
    end
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_d[i] = (i == SP_INDEX) ? SP_RESET : 32'd0;
      end
      read_data_1_d = 32'd0;
      read_data_2_d = 32'd0;
    end
  end

  // State register for the storage array and both read latches.
  always_ff @(posedge clk) begin
    regs_q        <= regs_d;
    read_data_1_q <= read_data_1_d;
    read_data_2_q <= read_data_2_d;
  end

  assign read_data_1 = read_data_1_q;
  assign read_data_2 = read_data_2_q;

  // The debug port shows committed storage only, not a write that is in flight.
  assign dbg_data = (dbg_reg == 5'd0) ? 32'd0 : regs_q[dbg_reg];

endmodule
